// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and a single-port 64-bit memory.
// The arbiter takes the slave view; the requesters plus memory take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 13
);
    // Handshake: a requester raises *_req with stable fields and holds it;
    // the request is accepted in any cycle where *_req=1 and *_stall=0.
    // Reads return *_valid exactly one cycle after acceptance; writes never do.
    logic              if_req;
    logic [63:0]       if_addr;
    logic              if_stall;
    logic              if_valid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [63:0]       d_addr;
    logic [63:0]       d_wdata;
    logic [7:0]        d_wstrb;
    logic              d_stall;
    logic              d_valid;
    logic [63:0]       d_rdata;

    logic              mem_en;
    logic [7:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and data access.
// Data has priority unless fetch has been starved for STARVE_MAX cycles.
module mem_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state,
    output logic [3:0]   dbg_starve_cnt
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nx;
    logic [3:0] starve_cnt;
    logic       if_hi_q;
    logic       if_prio;
    logic       if_grant;
    logic       d_grant;
    logic       unused_addr;

    // Grants are qualified by reset so every output is 0 the moment reset drops.
    assign if_prio  = (starve_cnt == STARVE_LIM);
    assign d_grant  = reset & bus.d_req & ~(bus.if_req & if_prio);
    assign if_grant = reset & bus.if_req & (~bus.d_req | if_prio);

    assign bus.if_stall = reset & bus.if_req & ~if_grant;
    assign bus.d_stall  = reset & bus.d_req & ~d_grant;

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    assign unused_addr = ^{bus.if_addr[63:ADDR_W+3], bus.if_addr[1:0],
                           bus.d_addr[63:ADDR_W+3], bus.d_addr[2:0]};

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 8'h00;
        bus.mem_addr  = '0;
        bus.mem_wdata = 64'h0;
        if (if_grant) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr[ADDR_W+2:3];
        end else if (d_grant) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.d_addr[ADDR_W+2:3];
            if (bus.d_we) begin
                bus.mem_we    = bus.d_wstrb;
                bus.mem_wdata = bus.d_wdata;
            end
        end
    end

    // State register, plus the fetch half-word select captured at grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            if_hi_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (if_grant) begin
                if_hi_q <= bus.if_addr[2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (!bus.if_req || if_grant) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Re-evaluated every cycle, so a new grant overlaps the previous response.
    always_comb begin
        state_nx = IDLE;
        if (if_grant) begin
            state_nx = RESP_IF;
        end else if (d_grant && !bus.d_we) begin
            state_nx = RESP_D;
        end
    end

    always_comb begin
        bus.if_valid = 1'b0;
        bus.if_rdata = 32'h0;
        bus.d_valid  = 1'b0;
        bus.d_rdata  = 64'h0;
        case (state)
            RESP_IF: begin
                bus.if_valid = 1'b1;
                bus.if_rdata = if_hi_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
            end
            RESP_D: begin
                bus.d_valid = 1'b1;
                bus.d_rdata = bus.mem_rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 13, word-index width of the shared 64-bit memory.
REQ-002 Parameter: STARVE_MAX, default 3, consecutive denied fetch cycles before fetch is forced priority (range 1..15).
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction fetch request; held with stable if_addr until granted.
REQ-006 if_addr  input  64  fetch byte address.
REQ-007 if_stall  output  1  fetch request not granted this cycle.
REQ-008 if_valid  output  1  fetch read data valid.
REQ-009 if_rdata  output  32  fetched instruction.
REQ-010 d_req  input  1  data request; held with stable fields until granted.
REQ-011 d_we  input  1  1 = write, 0 = read.
REQ-012 d_addr  input  64  data byte address.
REQ-013 d_wdata  input  64  write data, lane-aligned.
REQ-014 d_wstrb  input  8  byte write enables.
REQ-015 d_stall  output  1  data request not granted this cycle.
REQ-016 d_valid  output  1  data read data valid (reads only).
REQ-017 d_rdata  output  64  raw 64-bit word read.
REQ-018 mem_en  output  1  memory access enable.
REQ-019 mem_we  output  8  memory byte write enables.
REQ-020 mem_addr  output  ADDR_W  memory word address.
REQ-021 mem_wdata  output  64  memory write data.
REQ-022 mem_rdata  input  64  memory read data, valid one cycle after a read issue.

Function
REQ-023 One access issued per cycle; grant decision combinational from current requests and starvation counter.
REQ-024 Grant rule: d_req wins over if_req, except when starve_cnt == STARVE_MAX, then if_req wins.
REQ-025 if_stall = if_req & ~if_grant; d_stall = d_req & ~d_grant; never asserted without the matching req.
REQ-026 Granted fetch: mem_en=1, mem_we=0, mem_addr=if_addr[ADDR_W+2:3].
REQ-027 Granted data read: mem_en=1, mem_we=0, mem_addr=d_addr[ADDR_W+2:3]; granted write: mem_we=d_wstrb, mem_wdata=d_wdata, completes in grant cycle, no d_valid.
REQ-028 No grant: mem_en=0, mem_we=0, mem_addr and mem_wdata 0.
REQ-029 Address bits above ADDR_W+2 ignored (wrap-around); bits [2:0] ignored except if_addr[2].
REQ-030 Response FSM states: IDLE, RESP_IF, RESP_D; next state = RESP_IF on fetch grant, RESP_D on data-read grant, else IDLE; evaluated every cycle, so back-to-back grants pipeline.
REQ-031 In RESP_IF: if_valid=1, if_rdata = mem_rdata[63:32] if registered if_addr[2]=1 else mem_rdata[31:0].
REQ-032 In RESP_D: d_valid=1, d_rdata=mem_rdata.
REQ-033 rdata outputs are 0 whenever the matching valid is 0; read latency exactly 1 cycle from grant.
REQ-034 starve_cnt (4 bit): +1 on cycles with if_req=1 and not granted, saturating at STARVE_MAX; cleared on fetch grant or if_req=0.
REQ-035 Requests dropped before grant are discarded with no side effects.

Reset
REQ-036 reset low: state IDLE, starve_cnt 0, registered if_addr[2] 0, all outputs 0 immediately (asynchronous), including combinational grants.
REQ-037 Reset asserted with a read outstanding: the response is discarded; no valid after reset release.
REQ-038 First grant possible on the first rising edge after reset goes high.

Verification
REQ-039 if_req only, if_addr=0x104, mem word 0xAAAA_BBBB_1111_2222 -> mem_addr=0x20, next cycle if_valid=1, if_rdata=0xAAAA_BBBB.
REQ-040 d_req write d_addr=0x18, d_wstrb=0x0F, d_wdata=0x55 -> mem_we=0x0F, mem_addr=0x3 in same cycle, d_valid stays 0.
REQ-041 STARVE_MAX=3, d_req and if_req held high -> data granted cycles 0,1,2, fetch granted cycle 3, if_stall=1 for cycles 0-2, counter back to 0.
REQ-042 Alternating fetch read then data read on consecutive cycles -> if_valid then d_valid on consecutive cycles, correct data, no bubble.
REQ-043 Data read granted, reset low before next edge -> d_valid never asserted; all outputs 0 during reset.
REQ-044 if_addr=0xFFFF_0000_0000_0008 with ADDR_W=13 -> mem_addr=0x0001.
